data_memory_responder: RTL and testbench
========================================

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024: number of 32-bit words stored.
REQ-002 The block SHALL have parameter LATENCY, default 1, legal range 1..4: cycles from request acceptance to response.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port req_i, input, mem_req_t {valid, addr[31:0], we, be[3:0], wdata[31:0]}: the request from the initiator.
REQ-006 The block SHALL have port resp_o, output, mem_resp_t {ready, valid, rdata[31:0], err}: the response to the initiator.
REQ-007 The block SHALL have port err_count_o, output, 16 bits: saturating count of error responses issued.

Function
REQ-008 The block SHALL implement a three-state FSM with states IDLE, WAIT and RESP.
- IDLE: resp_o.ready=1, resp_o.valid=0.
- WAIT: resp_o.ready=0, resp_o.valid=0.
- RESP: resp_o.ready=1, resp_o.valid=1.
REQ-009 The block SHALL accept a request on a rising edge where req_i.valid=1 and resp_o.ready=1; the fields addr, we, be and wdata SHALL be captured on that edge.
REQ-010 The block SHALL ignore req_i entirely while resp_o.ready=0; a held req_i.valid SHALL be accepted on the first edge at which ready is 1.
REQ-011 The block SHALL assert resp_o.valid for exactly one cycle, LATENCY cycles after acceptance; an acceptance at edge N SHALL give valid high between edges N+LATENCY-1 and N+LATENCY.
- LATENCY=1: IDLE to RESP directly.
- LATENCY>1: IDLE to WAIT; a down-counter of LATENCY-1 cycles, reloaded on acceptance, moves WAIT to RESP.
REQ-012 On the RESP exit edge, the FSM SHALL go to WAIT (or to RESP if LATENCY=1) when a new request is accepted on that edge, and SHALL go to IDLE otherwise; back-to-back throughput SHALL be one request per LATENCY cycles.
REQ-013 A request SHALL be an error when addr[1:0]≠0 or addr[31:2]≥DEPTH.
REQ-014 A read (we=0) without error SHALL return mem[addr[31:2]] on resp_o.rdata during the RESP cycle; be SHALL be ignored for reads.
REQ-015 A write without error SHALL update byte i of mem[addr[31:2]] with wdata[8i+7:8i] for each be[i]=1, committed on the acceptance edge.
- A write with be=0 SHALL change nothing and SHALL respond with err=0.
REQ-016 Read data SHALL reflect all writes accepted before the read's acceptance edge; read-after-write to the same word SHALL return the new data.
REQ-017 An error request SHALL NOT modify memory and SHALL respond with rdata=0 and err=1.
REQ-018 A write response SHALL carry rdata=0.
REQ-019 resp_o.rdata and resp_o.err SHALL be 0 in every cycle where resp_o.valid=0.
REQ-020 err_count_o SHALL increment by 1 on each RESP cycle with err=1 and SHALL saturate at 16'hFFFF.

Reset
REQ-021 While rst=1, the FSM SHALL be in IDLE, the latency counter and captured request SHALL be 0, and the outputs SHALL be resp_o={ready:1, valid:0, rdata:0, err:0} and err_count_o=0.
REQ-022 Reset SHALL NOT clear memory contents.
REQ-023 Reset asserted mid-operation SHALL abort any pending response, so no resp_o.valid is issued for it; a write already accepted SHALL remain committed.
REQ-024 The first request after rst deasserts SHALL be accepted on the first rising edge at which req_i.valid=1.

Verification
REQ-025 LATENCY=1: write addr=0x10, be=4'hF, wdata=0xDEADBEEF, then read 0x10 -> the read's RESP cycle gives rdata=0xDEADBEEF, err=0, one cycle after acceptance.
REQ-026 LATENCY=3: read 0x10 -> ready=0 for 2 cycles, valid high in the 3rd cycle after acceptance, then an immediate back-to-back request is accepted in the RESP cycle.
REQ-027 Byte-enable merge: mem[4]=0x11223344, write addr=0x10, be=4'b0101, wdata=0xAABBCCDD -> a read of 0x10 returns 0x11BB33DD.
REQ-028 Errors: read addr=0x2 and write addr=DEPTH*4 -> both give err=1, rdata=0, memory unchanged, err_count_o=2.
REQ-029 Reset: assert rst during WAIT with LATENCY=4 -> no valid pulse occurs, outputs return to their reset values immediately, and memory contents are preserved.
REQ-030 Saturation: force 65537 error responses -> err_count_o holds 16'hFFFF.

Source files
------------

// File: rtl/data_memory_responder.sv
// data_memory_responder: word-addressed data memory with fixed-latency request/response handshake
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset (memory contents are kept)
//   req_i        request {valid, addr, we, be, wdata}
//   resp_o       response {ready, valid, rdata, err}
//   err_count_o  saturating count of error responses
package data_memory_responder_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_req_t;
    typedef struct packed {
        logic        ready;
        logic        valid;
        logic [31:0] rdata;
        logic        err;
    } mem_resp_t;
endpackage

module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  mem_req_t    req_i,
    output mem_resp_t   resp_o,
    output logic [15:0] err_count_o
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    // WAIT lasts LATENCY-1 cycles; the counter exits at 0
    localparam logic [1:0] CNT_LOAD = LATENCY > 1 ? 2'(LATENCY - 2) : 2'd0;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [31:0] mem [DEPTH];
    logic        accept, req_err, rsp_err;
    logic [AW-1:0] widx, ridx;

    assign accept  = req_i.valid && state_q != WAIT;
    assign req_err = req_i.addr[1:0] != 2'b00 || req_i.addr[31:2] >= 30'(DEPTH);
    assign rsp_err = addr_q[1:0] != 2'b00 || addr_q[31:2] >= 30'(DEPTH);
    assign widx    = req_i.addr[AW+1:2];
    assign ridx    = addr_q[AW+1:2];
    assign err_count_o = err_cnt_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        we_d      = we_q;
        err_cnt_d = err_cnt_q;
        resp_o       = '0;
        resp_o.ready = state_q != WAIT;
        resp_o.valid = state_q == RESP;
        if (state_q == RESP) begin
            resp_o.err   = rsp_err;
            resp_o.rdata = (rsp_err || we_q) ? 32'h0 : mem[ridx];
            err_cnt_d    = (rsp_err && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
            state_d      = IDLE;
        end
        if (state_q == WAIT) begin
            state_d = cnt_q == 2'd0 ? RESP : WAIT;
            cnt_d   = cnt_q - 2'd1;
        end
        if (accept) begin
            state_d = LATENCY == 1 ? RESP : WAIT;
            cnt_d   = CNT_LOAD;
            addr_d  = req_i.addr;
            we_d    = req_i.we;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Writes commit on the acceptance edge; no reset so contents survive rst
    always_ff @(posedge clk) begin
        if (!rst && accept && req_i.we && !req_err)
            for (int i = 0; i < 4; i++)
                if (req_i.be[i]) mem[widx][8*i +: 8] <= req_i.wdata[8*i +: 8];
    end
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: self-checking bench for three responders (LATENCY 1, 3, 4)
module tb_data_memory_responder;
    import data_memory_responder_pkg::*;
    localparam int DEPTH = 64;
    logic        clk = 1'b0;
    logic        rst;
    mem_req_t    req [3];
    mem_resp_t   resp [3];
    logic [15:0] ec [3];
    int          n_chk = 0, n_fail = 0;
    logic [31:0] mdl [3][DEPTH];
    int          mec [3];
    logic [31:0] got, junk;
    mem_resp_t   rst_exp;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_memory_responder #(.DEPTH(DEPTH), .LATENCY(g == 0 ? 1 : g == 1 ? 3 : 4)) u_dut (
            .clk(clk), .rst(rst), .req_i(req[g]), .resp_o(resp[g]), .err_count_o(ec[g]));
    end

    function automatic int lat(input int d);
        return d == 0 ? 1 : d == 1 ? 3 : 4;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; returns at the falling edge inside the response cycle
    task automatic xact(input int d, input logic [31:0] a, input logic we, input logic [3:0] be,
                        input logic [31:0] wd, output logic [31:0] rd, input bit hold = 0);
        bit e;
        logic [31:0] exp_rd;
        e = (a % 4 != 0) || (a / 4 >= DEPTH);
        exp_rd = 32'h0;
        if (!e && we)
            for (int i = 0; i < 4; i++) if (be[i]) mdl[d][a/4][8*i +: 8] = wd[8*i +: 8];
        if (!e && !we) exp_rd = mdl[d][a/4];
        chk("ready_before_accept", resp[d].ready, 1);
        req[d] = '{valid: 1'b1, addr: a, we: we, be: be, wdata: wd};
        @(posedge clk);
        for (int c = 1; c <= lat(d); c++) begin
            @(negedge clk);
            if (c == 1 && !hold) req[d].valid = 1'b0;
            chk("valid_timing", resp[d].valid, c == lat(d));
            chk("ready_timing", resp[d].ready, c == lat(d));
        end
        rd = resp[d].rdata;
        chk("rdata", resp[d].rdata, exp_rd);
        chk("err", resp[d].err, e);
        chk("err_count", ec[d], mec[d]);
        if (e && mec[d] < 16'hFFFF) mec[d]++;
    endtask

    task automatic idle(input int d);
        @(negedge clk);
        chk("idle_valid", resp[d].valid, 0);
        chk("idle_ready", resp[d].ready, 1);
        chk("idle_rdata", resp[d].rdata, 0);
        chk("idle_err", resp[d].err, 0);
    endtask

    initial begin
        rst_exp = '{ready: 1'b1, valid: 1'b0, rdata: 32'h0, err: 1'b0};
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            req[d] = '0;
            mec[d] = 0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("reset_resp", resp[d], rst_exp);
            chk("reset_err_count", ec[d], 0);
        end
        rst = 1'b0;
        // Fill every word so reads have defined expectations
        for (int d = 0; d < 3; d++) begin
            for (int w = 0; w < DEPTH; w++) xact(d, w * 4, 1'b1, 4'hF, $urandom, junk);
            idle(d);
        end
        // Write then read back
        xact(0, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF, junk);
        xact(0, 32'h10, 1'b0, 4'h0, 32'h0, got);
        chk("raw_deadbeef", got, 32'hDEADBEEF);
        idle(0);
        // Byte-enable merge
        xact(0, 32'h10, 1'b1, 4'hF, 32'h11223344, junk);
        xact(0, 32'h10, 1'b1, 4'b0101, 32'hAABBCCDD, junk);
        xact(0, 32'h10, 1'b0, 4'hF, 32'h0, got);
        chk("be_merge", got, 32'h11BB33DD);
        xact(0, 32'h14, 1'b1, 4'h0, 32'hFFFFFFFF, junk);
        idle(0);
        // Error requests leave memory alone and count
        xact(0, 32'h2, 1'b0, 4'hF, 32'h0, junk);
        xact(0, DEPTH * 4, 1'b1, 4'hF, 32'h12345678, junk);
        idle(0);
        chk("err_count_two", ec[0], 2);
        xact(0, 32'h0, 1'b0, 4'h0, 32'h0, junk);
        xact(0, 32'h10, 1'b0, 4'h0, 32'h0, got);
        chk("be_merge_kept", got, 32'h11BB33DD);
        idle(0);
        // LATENCY=3: request held through WAIT is taken only at the RESP exit edge
        xact(1, 32'h10, 1'b0, 4'h0, 32'h0, junk, 1);
        xact(1, 32'h10, 1'b0, 4'h0, 32'h0, junk);
        xact(1, 32'h14, 1'b1, 4'h3, $urandom, junk);
        xact(1, 32'h14, 1'b0, 4'h0, 32'h0, junk);
        idle(1);
        // Random traffic against the model
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 60; n++) begin
                logic [31:0] a;
                a = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, DEPTH * 4 + 15))
                                              : 32'($urandom_range(0, DEPTH - 1) * 4);
                xact(d, a, 1'($urandom), 4'($urandom), $urandom, junk);
                if ($urandom_range(0, 2) == 0) idle(d);
            end
            idle(d);
            chk("rand_err_count", ec[d], mec[d]);
        end
        // Reset during WAIT aborts the response but keeps the accepted write
        req[2] = '{valid: 1'b1, addr: 32'h24, we: 1'b1, be: 4'hF, wdata: 32'hCAFEF00D};
        mdl[2][9] = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        req[2].valid = 1'b0;
        chk("wait_ready_low", resp[2].ready, 0);
        rst = 1'b1;
        #1;
        chk("async_reset_resp", resp[2], rst_exp);
        for (int d = 0; d < 3; d++) begin
            chk("async_reset_err_count", ec[d], 0);
            mec[d] = 0;
        end
        repeat (3) begin
            @(negedge clk);
            chk("reset_no_valid", resp[2].valid, 0);
        end
        rst = 1'b0;
        repeat (4) idle(2);
        xact(2, 32'h24, 1'b0, 4'h0, 32'h0, got);
        chk("write_survives_reset", got, 32'hCAFEF00D);
        idle(2);
        xact(0, 32'h10, 1'b0, 4'h0, 32'h0, got);
        chk("mem_survives_reset", got, 32'h11BB33DD);
        idle(0);
        // Saturation: continuous back-to-back error reads
        req[0] = '{valid: 1'b1, addr: 32'h2, we: 1'b0, be: 4'h0, wdata: 32'h0};
        repeat (65534) @(posedge clk);
        @(negedge clk);
        chk("err_count_near_sat", ec[0], 65533);
        repeat (3) @(posedge clk);
        @(negedge clk);
        req[0].valid = 1'b0;
        chk("err_count_sat_a", ec[0], 16'hFFFF);
        @(negedge clk);
        chk("err_count_sat_b", ec[0], 16'hFFFF);
        idle(0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
